tx_frame_fifo: RTL and testbench
================================

TX_FRAME_FIFO -- requirements
Module: tx_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning data RAM depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter META_DEPTH, default 128, meaning max committed frames queued (power of 2).
REQ-003 SHALL have parameter MAX_FRAME_WORDS, default 384, meaning worst-case frame size used for the ready threshold.
REQ-004 SHALL have port clk  in  1  sole clock (fabric clock domain).
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_start  in  1  fabric begins a new frame.
REQ-007 SHALL have port wr_en  in  1  wr_data word valid.
REQ-008 SHALL have port wr_data  in  32  frame bytes, MSB first.
REQ-009 SHALL have port wr_bytes_valid  in  3  valid bytes in word, 1..4.
REQ-010 SHALL have port wr_commit  in  1  frame complete, make visible.
REQ-011 SHALL have port wr_drop  in  1  abort current frame.
REQ-012 SHALL have port tx_fifo_ready  out  1  room for one MAX_FRAME_WORDS frame plus a meta slot.
REQ-013 SHALL have port tx_start / tx_data_valid / tx_bytes_valid[2:0] / tx_data[31:0] / tx_commit  out  MAC TX bus.
REQ-014 SHALL have port tx_ready  in  1  MAC can accept a word this cycle.
REQ-015 SHALL have port overflow_drops  out  32  frames dropped for overflow, saturating.

Function
REQ-016 SHALL be store-and-forward: no word of a frame reaches the tx_* bus before its wr_commit.
REQ-017 SHALL use a tentative write pointer; wr_commit copies it to the committed pointer and pushes {word count, last bytes_valid} to the meta FIFO.
REQ-018 SHALL on wr_drop rewind the tentative pointer to the committed pointer; no meta push.
REQ-019 SHALL on wr_start while a frame is open discard the open frame as wr_drop, then start the new one.
REQ-020 SHALL on wr_en with data RAM full mark the frame overflowed, discard further words, and treat its wr_commit as wr_drop plus increment overflow_drops.
REQ-021 SHALL use ADDR_BITS+1 pointers; full = MSBs differ and lower bits equal; wrap-around silent.
REQ-022 SHALL compute tx_fifo_ready registered: free words >= MAX_FRAME_WORDS and meta not full; one-cycle latency after the cause.
REQ-023 SHALL run read FSM IDLE -> START -> DATA -> COMMIT -> IDLE.
REQ-024 SHALL leave IDLE when meta non-empty; START pulses tx_start for one cycle and issues the first RAM read.
REQ-025 SHALL in DATA output one word per cycle with tx_ready high; tx_ready low holds tx_data stable with tx_data_valid low; RAM read latency is one cycle.
REQ-026 SHALL drive tx_bytes_valid = 4 except the final word, which uses the stored last bytes_valid.
REQ-027 SHALL pulse tx_commit one cycle after the last word, pop meta, free the frame's words, and return to IDLE.
REQ-028 SHALL allow simultaneous wr_commit and frame read completion; both pointer updates take effect that cycle.
REQ-029 SHALL never emit a partial or dropped frame; back-to-back frames have a minimum one-cycle gap (the COMMIT state).

Reset
REQ-030 SHALL on rst_n low clear all pointers, meta FIFO, and counters; FSM to IDLE; tx_* outputs 0; tx_fifo_ready 0, then 1 the first clk after release.
REQ-031 SHALL discard any frame in flight when reset asserts; no tx_commit is emitted for it.

Configuration
REQ-032 SHALL with TX_FRAME_FIFO_PERF_EN defined add outputs frames_sent[31:0] and frames_dropped[31:0] (abort plus overflow), saturating and reset to 0.
REQ-033 SHALL without TX_FRAME_FIFO_PERF_EN omit those ports and counters; overflow_drops remains.

Structure
REQ-034 SHALL place the TX bus field widths, the bytes_valid encoding and the default MAX_FRAME_WORDS in the shared Ethernet package.
REQ-035 SHALL instantiate one sub-module, tx_fifo_ram: a simple dual-port, single-clock RAM with registered read.

Verification
REQ-036 SHALL cover: 3-word frame (last bytes_valid 2), tx_ready high -> tx_start, 3 valid words, last tx_bytes_valid 2, tx_commit; 5 cycles IDLE-to-IDLE.
REQ-037 SHALL cover: 10-word frame then wr_drop -> no tx activity; the following frame emits intact and the pointers are as if no drop occurred.
REQ-038 SHALL cover: DEPTH=512 filled to 129 free words -> tx_fifo_ready 0; drain 1 frame -> ready 1 one cycle after tx_commit.
REQ-039 SHALL cover: tx_ready toggling 1/0 across a 6-word frame -> words in order, none repeated or lost.
REQ-040 SHALL cover: write exceeding free space then wr_commit -> frame absent, overflow_drops = 1.
REQ-041 SHALL cover: rst_n pulsed mid-DATA -> outputs 0, next frame emitted cleanly.

Source files
------------

// File: rtl/tx_frame_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tx_frame_fifo_pkg
//  Purpose  : Shared Ethernet TX definitions: bus field widths, bytes_valid
//             encoding, default frame size and read-side FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package tx_frame_fifo_pkg;

  // MAC TX bus field widths
  localparam int TX_DATA_W = 32;
  localparam int TX_BV_W   = 3;

  // bytes_valid encoding: 1..4 valid bytes, MSB first; 4 marks a full word
  localparam logic [TX_BV_W-1:0] TX_BV_FULL = 3'd4;

  // Worst-case frame in 32-bit words (1536-byte jumbo-less frame)
  localparam int DEFAULT_MAX_FRAME_WORDS = 384;

  // Read-side frame sequencer states
  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_START  = 2'd1,
    RD_DATA   = 2'd2,
    RD_COMMIT = 2'd3
  } rd_state_t;

  // Saturating add of a small increment to a 32-bit event counter
  function automatic logic [31:0] sat_add32(input logic [31:0] value,
                                            input logic [1:0]  inc);
    logic [32:0] sum;
    sum = {1'b0, value} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tx_fifo_ram
//  Purpose  : Simple dual-port, single-clock RAM with a registered read port.
//             The read register holds its value while re is low, which lets
//             the consumer stall without re-reading.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: storage array carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: one-cycle latency, output held while re is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/tx_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tx_frame_fifo
//  Purpose  : Store-and-forward TX frame FIFO between fabric and MAC. Frames
//             are written behind a tentative pointer and become visible only
//             on commit; a meta FIFO carries {word count, last bytes_valid}
//             per committed frame to the read sequencer.
//  Options  : define TX_FRAME_FIFO_PERF_EN to add frames_sent/frames_dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_frame_fifo
  import tx_frame_fifo_pkg::*;
#(
  parameter int DEPTH           = 2048,
  parameter int META_DEPTH      = 128,
  parameter int MAX_FRAME_WORDS = DEFAULT_MAX_FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_start,
  input  logic                 wr_en,
  input  logic [TX_DATA_W-1:0] wr_data,
  input  logic [TX_BV_W-1:0]   wr_bytes_valid,
  input  logic                 wr_commit,
  input  logic                 wr_drop,
  output logic                 tx_fifo_ready,
  output logic                 tx_start,
  output logic                 tx_data_valid,
  output logic [TX_BV_W-1:0]   tx_bytes_valid,
  output logic [TX_DATA_W-1:0] tx_data,
  output logic                 tx_commit,
  input  logic                 tx_ready,
  output logic [31:0]          overflow_drops
`ifdef TX_FRAME_FIFO_PERF_EN
  ,
  output logic [31:0]          frames_sent,
  output logic [31:0]          frames_dropped
`endif
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int PW        = ADDR_BITS + 1;
  localparam int META_BITS = $clog2(META_DEPTH);
  localparam int MW        = META_BITS + 1;
  localparam int ENTRY_W   = PW + TX_BV_W;

  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_WORDS = PW'(DEPTH);
  localparam logic [MW-1:0] META_ONE    = MW'(1);

  // ---------------- write side ----------------
  logic [PW-1:0]      wr_tent_q, wr_tent_d;
  logic [PW-1:0]      wr_cmt_q, wr_cmt_d;
  logic               frame_open_q, frame_open_d;
  logic               frame_ovf_q, frame_ovf_d;
  logic [TX_BV_W-1:0] last_bv_q, last_bv_d;
  logic [31:0]        ovf_drops_q, ovf_drops_d;
  logic [PW-1:0]      tent_base, tent_next, frame_cnt;
  logic               open_now, ovf_now, ram_full, ram_we, meta_push;

  // ---------------- meta FIFO ----------------
  logic [ENTRY_W-1:0] meta_mem_q [META_DEPTH];
  logic [MW-1:0]      meta_wptr_q, meta_wptr_d;
  logic [MW-1:0]      meta_rptr_q, meta_rptr_d;
  logic               meta_empty, meta_full;
  logic [ENTRY_W-1:0] meta_head, meta_wdata;

  // ---------------- read side ----------------
  rd_state_t          state_q, state_d;
  logic [PW-1:0]      rd_free_q, rd_free_d;
  logic [PW-1:0]      fetch_q, fetch_d;
  logic [PW-1:0]      words_left_q, words_left_d;
  logic [TX_BV_W-1:0] rd_last_bv_q, rd_last_bv_d;
  logic               tx_start_q, tx_start_d;
  logic               tx_commit_q, tx_commit_d;
  logic               data_active_q, data_active_d;
  logic               ram_re;
  logic [TX_DATA_W-1:0] ram_rdata;

  // ---------------- ready flag ----------------
  logic               ready_q, ready_d;
  logic [PW-1:0]      used_words, free_words;

`ifdef TX_FRAME_FIFO_PERF_EN
  logic [31:0]        frames_sent_q, frames_sent_d;
  logic [31:0]        frames_dropped_q, frames_dropped_d;
  logic [1:0]         drop_inc;
`endif

  assign meta_empty = (meta_wptr_q == meta_rptr_q);
  assign meta_full  = (meta_wptr_q[META_BITS] != meta_rptr_q[META_BITS]) &&
                      (meta_wptr_q[META_BITS-1:0] == meta_rptr_q[META_BITS-1:0]);
  assign meta_head  = meta_mem_q[meta_rptr_q[META_BITS-1:0]];
  assign meta_wdata = {frame_cnt, last_bv_d};

  // Write-side next state: start/restart, word append, overflow, commit/drop
  always_comb begin
    wr_cmt_d    = wr_cmt_q;
    last_bv_d   = last_bv_q;
    ovf_drops_d = ovf_drops_q;
    ram_we      = 1'b0;
    meta_push   = 1'b0;
`ifdef TX_FRAME_FIFO_PERF_EN
    drop_inc    = 2'd0;
`endif
    // A new start always rebases on the committed pointer, which also
    // discards a frame that was still open.
    tent_base = wr_start ? wr_cmt_q : wr_tent_q;
    open_now  = wr_start | frame_open_q;
    ovf_now   = wr_start ? 1'b0 : frame_ovf_q;
`ifdef TX_FRAME_FIFO_PERF_EN
    if (wr_start && frame_open_q) begin
      drop_inc = drop_inc + 2'd1;
    end
`endif
    ram_full  = (tent_base[ADDR_BITS] != rd_free_q[ADDR_BITS]) &&
                (tent_base[ADDR_BITS-1:0] == rd_free_q[ADDR_BITS-1:0]);
    tent_next = tent_base;

    if (wr_en && open_now) begin
      if (ovf_now || ram_full) begin
        ovf_now = 1'b1;
      end else begin
        ram_we    = 1'b1;
        tent_next = tent_base + PTR_ONE;
        last_bv_d = wr_bytes_valid;
      end
    end

    frame_cnt = tent_next - wr_cmt_q;

    if (open_now && wr_drop) begin
      tent_next = wr_cmt_q;
      open_now  = 1'b0;
`ifdef TX_FRAME_FIFO_PERF_EN
      drop_inc  = drop_inc + 2'd1;
`endif
    end else if (open_now && wr_commit) begin
      if (ovf_now || meta_full) begin
        // No room for the data or its descriptor: discard and count it
        tent_next   = wr_cmt_q;
        ovf_drops_d = sat_add32(ovf_drops_q, 2'd1);
`ifdef TX_FRAME_FIFO_PERF_EN
        drop_inc    = drop_inc + 2'd1;
`endif
      end else if (frame_cnt == '0) begin
        // An empty frame has nothing to send; it behaves as an abort
        tent_next = wr_cmt_q;
`ifdef TX_FRAME_FIFO_PERF_EN
        drop_inc  = drop_inc + 2'd1;
`endif
      end else begin
        wr_cmt_d  = tent_next;
        meta_push = 1'b1;
      end
      open_now = 1'b0;
    end

    wr_tent_d    = tent_next;
    frame_open_d = open_now;
    frame_ovf_d  = ovf_now;
    meta_wptr_d  = meta_push ? (meta_wptr_q + META_ONE) : meta_wptr_q;
  end

  // Write-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_tent_q    <= '0;
      wr_cmt_q     <= '0;
      frame_open_q <= 1'b0;
      frame_ovf_q  <= 1'b0;
      last_bv_q    <= TX_BV_FULL;
      ovf_drops_q  <= '0;
      meta_wptr_q  <= '0;
    end else begin
      wr_tent_q    <= wr_tent_d;
      wr_cmt_q     <= wr_cmt_d;
      frame_open_q <= frame_open_d;
      frame_ovf_q  <= frame_ovf_d;
      last_bv_q    <= last_bv_d;
      ovf_drops_q  <= ovf_drops_d;
      meta_wptr_q  <= meta_wptr_d;
    end
  end

  // Meta FIFO storage; occupancy is tracked purely by the pointers
  always_ff @(posedge clk) begin
    if (meta_push) begin
      meta_mem_q[meta_wptr_q[META_BITS-1:0]] <= meta_wdata;
    end
  end

  // Read sequencer next state: fetch is always one word ahead of the bus
  always_comb begin
    state_d       = state_q;
    rd_free_d     = rd_free_q;
    fetch_d       = fetch_q;
    words_left_d  = words_left_q;
    rd_last_bv_d  = rd_last_bv_q;
    meta_rptr_d   = meta_rptr_q;
    data_active_d = data_active_q;
    tx_start_d    = 1'b0;
    tx_commit_d   = 1'b0;
    ram_re        = 1'b0;
`ifdef TX_FRAME_FIFO_PERF_EN
    frames_sent_d = frames_sent_q;
`endif
    case (state_q)
      RD_IDLE: begin
        if (!meta_empty) begin
          words_left_d = meta_head[ENTRY_W-1:TX_BV_W];
          rd_last_bv_d = meta_head[TX_BV_W-1:0];
          fetch_d      = rd_free_q;
          tx_start_d   = 1'b1;
          state_d      = RD_START;
        end
      end
      RD_START: begin
        ram_re        = 1'b1;
        fetch_d       = fetch_q + PTR_ONE;
        data_active_d = 1'b1;
        state_d       = RD_DATA;
      end
      RD_DATA: begin
        if (tx_ready) begin
          if (words_left_q == PTR_ONE) begin
            // Last word accepted: release the frame now so the ready flag
            // can recover one cycle after tx_commit.
            data_active_d = 1'b0;
            tx_commit_d   = 1'b1;
            rd_free_d     = fetch_q;
            meta_rptr_d   = meta_rptr_q + META_ONE;
            state_d       = RD_COMMIT;
`ifdef TX_FRAME_FIFO_PERF_EN
            frames_sent_d = sat_add32(frames_sent_q, 2'd1);
`endif
          end else begin
            ram_re       = 1'b1;
            fetch_d      = fetch_q + PTR_ONE;
            words_left_d = words_left_q - PTR_ONE;
          end
        end
      end
      RD_COMMIT: begin
        state_d = RD_IDLE;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  // Read sequencer state and registered bus controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RD_IDLE;
      rd_free_q     <= '0;
      fetch_q       <= '0;
      words_left_q  <= '0;
      rd_last_bv_q  <= TX_BV_FULL;
      meta_rptr_q   <= '0;
      data_active_q <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_commit_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_free_q     <= rd_free_d;
      fetch_q       <= fetch_d;
      words_left_q  <= words_left_d;
      rd_last_bv_q  <= rd_last_bv_d;
      meta_rptr_q   <= meta_rptr_d;
      data_active_q <= data_active_d;
      tx_start_q    <= tx_start_d;
      tx_commit_q   <= tx_commit_d;
    end
  end

  // Space for a worst-case frame counts the open frame's words as used
  assign used_words = wr_tent_q - rd_free_q;
  assign free_words = DEPTH_WORDS - used_words;
  assign ready_d    = (32'(free_words) >= 32'(MAX_FRAME_WORDS)) && !meta_full;

  // Registered ready flag, one cycle behind pointer changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

`ifdef TX_FRAME_FIFO_PERF_EN
  assign frames_dropped_d = sat_add32(frames_dropped_q, drop_inc);

  // Optional frame statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_sent_q    <= '0;
      frames_dropped_q <= '0;
    end else begin
      frames_sent_q    <= frames_sent_d;
      frames_dropped_q <= frames_dropped_d;
    end
  end

  assign frames_sent    = frames_sent_q;
  assign frames_dropped = frames_dropped_q;
`endif

  tx_fifo_ram #(
    .WIDTH (TX_DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (tent_base[ADDR_BITS-1:0]),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (fetch_q[ADDR_BITS-1:0]),
    .rdata (ram_rdata)
  );

  assign tx_fifo_ready  = ready_q;
  assign tx_start       = tx_start_q;
  assign tx_commit      = tx_commit_q;
  assign tx_data_valid  = data_active_q & tx_ready;
  assign tx_data        = data_active_q ? ram_rdata : '0;
  assign tx_bytes_valid = !data_active_q ? '0 :
                          ((words_left_q == PTR_ONE) ? rd_last_bv_q : TX_BV_FULL);
  assign overflow_drops = ovf_drops_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_frame_fifo
//  Purpose  : Directed self-checking bench for tx_frame_fifo (DEPTH=512).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frame_fifo;

  localparam int DEPTH      = 512;
  localparam int META_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_start, wr_en, wr_commit, wr_drop, tx_ready;
  logic [31:0] wr_data;
  logic [2:0]  wr_bytes_valid;
  logic        tx_fifo_ready, tx_start, tx_data_valid, tx_commit;
  logic [2:0]  tx_bytes_valid;
  logic [31:0] tx_data, overflow_drops;
`ifdef TX_FRAME_FIFO_PERF_EN
  logic [31:0] frames_sent, frames_dropped;
`endif

  always #5 clk = ~clk;

  tx_frame_fifo #(
    .DEPTH           (DEPTH),
    .META_DEPTH      (META_DEPTH),
    .MAX_FRAME_WORDS (384)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_start       (wr_start),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_bytes_valid (wr_bytes_valid),
    .wr_commit      (wr_commit),
    .wr_drop        (wr_drop),
    .tx_fifo_ready  (tx_fifo_ready),
    .tx_start       (tx_start),
    .tx_data_valid  (tx_data_valid),
    .tx_bytes_valid (tx_bytes_valid),
    .tx_data        (tx_data),
    .tx_commit      (tx_commit),
    .tx_ready       (tx_ready),
    .overflow_drops (overflow_drops)
`ifdef TX_FRAME_FIFO_PERF_EN
    ,
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: records every accepted word and start/commit timing
  int          cyc_cnt    = 0;
  int          n_start    = 0;
  int          n_commit   = 0;
  int          start_cyc  = 0;
  int          commit_cyc = 0;
  logic [31:0] mon_data[$];
  logic [2:0]  mon_bv[$];

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst_n) begin
      if (tx_start) begin
        n_start   <= n_start + 1;
        start_cyc <= cyc_cnt;
      end
      if (tx_commit) begin
        n_commit   <= n_commit + 1;
        commit_cyc <= cyc_cnt;
      end
      if (tx_data_valid) begin
        mon_data.push_back(tx_data);
        mon_bv.push_back(tx_bytes_valid);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic fill(input logic [31:0] seed, input int n, input logic [2:0] lbv);
    wr_start = 1'b1;
    cyc();
    wr_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en          = 1'b1;
      wr_data        = seed + 32'(i);
      wr_bytes_valid = (i == n - 1) ? lbv : 3'd4;
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic finish_frame(input bit commit);
    if (commit) wr_commit = 1'b1;
    else        wr_drop   = 1'b1;
    cyc();
    wr_commit = 1'b0;
    wr_drop   = 1'b0;
  endtask

  task automatic wait_commits(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_commit < target && k < budget) begin
      cyc();
      k++;
    end
    check(tag, n_commit, target);
  endtask

  task automatic check_frame(input int base, input logic [31:0] seed, input int n,
                             input logic [2:0] lbv, input string tag);
    for (int i = 0; i < n; i++) begin
      if (base + i < mon_data.size()) begin
        check($sformatf("%s_w%0d", tag, i), mon_data[base + i], seed + 32'(i));
        check($sformatf("%s_bv%0d", tag, i), 32'(mon_bv[base + i]),
              (i == n - 1) ? 32'(lbv) : 32'd4);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sb;
    int cb;
    int k;

    rst_n = 1'b0; wr_start = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; wr_drop = 1'b0;
    wr_data = '0; wr_bytes_valid = 3'd4; tx_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", tx_fifo_ready, 0);
    check("rst_start", tx_start, 0);
    check("rst_valid", tx_data_valid, 0);
    check("rst_commit", tx_commit, 0);
    check("rst_data", tx_data, 0);
    check("rst_ovf", overflow_drops, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_before_edge", tx_fifo_ready, 0);
    @(negedge clk);
    check("rel_ready_after_edge", tx_fifo_ready, 1);
    cyc();

    // 3-word frame, last word 2 bytes
    base = mon_data.size(); sb = n_start; cb = n_commit;
    fill(32'hA100_0000, 3, 3'd2);
    idle_cycles(3);
    check("t1_no_early_start", n_start - sb, 0);
    finish_frame(1);
    wait_commits(cb + 1, 30, "t1_commit");
    idle_cycles(2);
    check("t1_len", mon_data.size() - base, 3);
    check_frame(base, 32'hA100_0000, 3, 3'd2, "t1");
    check("t1_starts", n_start - sb, 1);
    check("t1_span", commit_cyc - start_cyc, 4);

    // Dropped frame leaves no trace; next frame intact
    base = mon_data.size(); sb = n_start; cb = n_commit;
    fill(32'hB200_0000, 10, 3'd1);
    finish_frame(0);
    idle_cycles(20);
    check("t2_drop_starts", n_start - sb, 0);
    check("t2_drop_words", mon_data.size() - base, 0);
    check("t2_drop_ready", tx_fifo_ready, 1);
    fill(32'hC300_0000, 4, 3'd3);
    finish_frame(1);
    wait_commits(cb + 1, 30, "t2_commit");
    idle_cycles(2);
    check("t2_len", mon_data.size() - base, 4);
    check_frame(base, 32'hC300_0000, 4, 3'd3, "t2");

    // tx_ready toggling across a 6-word frame
    base = mon_data.size(); cb = n_commit;
    tx_ready = 1'b0;
    fill(32'hD400_0000, 6, 3'd1);
    finish_frame(1);
    k = 0;
    while (n_commit < cb + 1 && k < 100) begin
      tx_ready = ~tx_ready;
      cyc();
      k++;
    end
    tx_ready = 1'b1;
    wait_commits(cb + 1, 5, "t3_commit");
    idle_cycles(2);
    check("t3_len", mon_data.size() - base, 6);
    check_frame(base, 32'hD400_0000, 6, 3'd1, "t3");

    // Overflowing frame is dropped and counted
    base = mon_data.size(); sb = n_start;
    fill(32'hE500_0000, 520, 3'd4);
    finish_frame(1);
    idle_cycles(10);
    check("t4_ovf_drops", overflow_drops, 1);
    check("t4_no_start", n_start - sb, 0);
    check("t4_no_words", mon_data.size() - base, 0);
    check("t4_ready_back", tx_fifo_ready, 1);

    // 129 free words -> not ready; draining one frame restores ready
    base = mon_data.size(); cb = n_commit;
    tx_ready = 1'b0;
    fill(32'h1100_0000, 300, 3'd3);
    finish_frame(1);
    fill(32'h2200_0000, 83, 3'd2);
    finish_frame(1);
    idle_cycles(2);
    check("t5_ready_low", tx_fifo_ready, 0);
    tx_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!tx_commit && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("t5_commit_seen", tx_commit, 1);
    check("t5_ready_at_commit", tx_fifo_ready, 0);
    @(negedge clk);
    check("t5_ready_after_commit", tx_fifo_ready, 1);
    cyc();
    wait_commits(cb + 2, 200, "t5_commit2");
    idle_cycles(2);
    check("t5_len", mon_data.size() - base, 383);
    check_frame(base, 32'h1100_0000, 300, 3'd3, "t5a");
    check_frame(base + 300, 32'h2200_0000, 83, 3'd2, "t5b");

    // Reset in the middle of DATA
    tx_ready = 1'b0;
    fill(32'h3300_0000, 5, 3'd2);
    finish_frame(1);
    idle_cycles(4);
    tx_ready = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", tx_data_valid, 0);
    check("t6_rst_data", tx_data, 0);
    check("t6_rst_bv", 32'(tx_bytes_valid), 0);
    check("t6_rst_commit", tx_commit, 0);
    check("t6_rst_ready", tx_fifo_ready, 0);
    check("t6_rst_ovf", overflow_drops, 0);
    cyc();
    rst_n = 1'b1;
    cb = n_commit; sb = n_start;
    idle_cycles(10);
    check("t6_no_commit", n_commit - cb, 0);
    check("t6_no_start", n_start - sb, 0);
    base = mon_data.size();
    fill(32'h4400_0000, 2, 3'd1);
    finish_frame(1);
    wait_commits(cb + 1, 30, "t6_commit");
    idle_cycles(2);
    check("t6_len", mon_data.size() - base, 2);
    check_frame(base, 32'h4400_0000, 2, 3'd1, "t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
